// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies use 32 shift-add steps and divides use 32 restoring
// shift-subtract steps. Both work on operand magnitudes and apply the sign
// in a single FIX cycle.
// Optional macro FAST_MUL_EN: multiplies are computed in one cycle at accept
// and go straight to FIX. Divide timing does not change.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [2:0]            op_q;
    logic [XLEN-1:0]       mag_b_q;
    logic [2*XLEN-1:0]     acc_q;
    logic [ITER_CNT_W-1:0] count_q;
    logic                  neg_q;
    logic                  a_neg_q;
    logic                  raw_q;

    logic                  a_signed;
    logic                  b_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [XLEN-1:0]       mag_a;
    logic [XLEN-1:0]       mag_b;
    logic                  div_zero;
    logic                  div_ovf;
    logic                  accept;
    logic                  bypass;

    logic [XLEN:0]         mul_sum;
    logic [2*XLEN-1:0]     mul_next;
    logic [XLEN:0]         div_shift;
    logic [XLEN:0]         div_diff;
    logic [2*XLEN-1:0]     div_next;
    logic [2*XLEN-1:0]     prod_fix;
    logic [XLEN-1:0]       quot_fix;
    logic [XLEN-1:0]       rem_fix;
    logic [2*XLEN-1:0]     fixed;
    logic [XLEN-1:0]       fix_value;

`ifdef FAST_MUL_EN
    // The low 64 bits of a product of operands sign-extended to 64 bits are
    // the same as the 33x33 signed product of the extended operands.
    logic [2*XLEN-1:0]     fast_prod;
    assign fast_prod = {{XLEN{a_neg}}, a} * {{XLEN{b_neg}}, b};
`endif

    // Decode operand signedness, magnitudes and the divide special cases at accept.
    always_comb begin
        a_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                   (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b000) || (op == 3'b001) ||
                   (op == 3'b100) || (op == 3'b110);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        mag_a    = a_neg ? -a : a;
        mag_b    = b_neg ? -b : b;
        div_zero = op[2] & (b == '0);
        div_ovf  = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        accept   = start & ~kill & ((state == IDLE) || (state == DONE));
`ifdef FAST_MUL_EN
        bypass   = div_zero | div_ovf | ~op[2];
`else
        bypass   = div_zero | div_ovf;
`endif
    end

    // One shift-add or restoring shift-subtract step, plus the FIX-cycle sign correction.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, mag_b_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quot_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fixed     = raw_q ? acc_q : (op_q[2] ? {rem_fix, quot_fix} : prod_fix);
        if (op_q[2])
            fix_value = op_q[1] ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
        else
            fix_value = (op_q[1:0] == 2'b00) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic. kill overrides everything, including a start in the same cycle.
    always_comb begin
        state_next = state;
        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start)
                        state_next = bypass ? FIX : CALC;
                    else
                        state_next = IDLE;
                end
                CALC:    state_next = (count_q == ITER_CNT_W'(XLEN-1)) ? FIX : CALC;
                FIX:     state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state == CALC) || (state == FIX);
        done = (state == DONE);
    end

    // Datapath: latch operands at accept, iterate in CALC, and register the result in FIX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            raw_q   <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            op_q    <= op;
            mag_b_q <= mag_b;
            count_q <= '0;
            neg_q   <= a_neg ^ b_neg;
            a_neg_q <= a_neg;
            raw_q   <= 1'b0;
            if (div_zero) begin
                acc_q <= {a, {XLEN{1'b1}}};
                raw_q <= 1'b1;
            end else if (div_ovf) begin
                acc_q <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                raw_q <= 1'b1;
`ifdef FAST_MUL_EN
            end else if (!op[2]) begin
                acc_q <= fast_prod;
                raw_q <= 1'b1;
`endif
            end else begin
                acc_q <= {{XLEN{1'b0}}, mag_a};
            end
        end else if (state == CALC && !kill) begin
            count_q <= count_q + 1'b1;
            acc_q   <= op_q[2] ? div_next : mul_next;
        end else if (state == FIX && !kill) begin
            result  <= fix_value;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Expected results and
// their due cycles are queued when an operation is started. They are popped
// and compared whenever done is seen.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 2;

    typedef struct {
        logic [31:0] value;
        int          due;
        string       tag;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] value;
        int          lat;
        string       tag;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];
    vec_t vecs[$];
    logic [31:0] last_exp;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Called right after a falling edge. Holds start for one cycle, then scrambles the operands.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] value, input int lat, input string tag);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e.value = value;
        e.due   = cyc + lat;
        e.tag   = tag;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 3'($urandom);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checkOutput("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.tag, "_result"}, result, e.value);
                checkOutput({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc   = 0;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        last_exp = '0;

        vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "mulh"});
        vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, "mulhsu"});
        vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "mulhu"});
        vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, "div_neg"});
        vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, "rem_neg"});
        vecs.push_back('{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT, "divu_zero"});
        vecs.push_back('{OP_REM,    32'd5,        32'd0,        32'd5,        SPC_LAT, "rem_zero"});
        vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT, "div_ovf"});
        vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC_LAT, "rem_ovf"});
        vecs.push_back('{OP_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT, "divu"});
        vecs.push_back('{OP_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT, "remu"});

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst_n = 1'b1;

        // MUL with a cycle-by-cycle busy profile
        @(negedge clk);
        applyStimulus(OP_MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "mul");
        for (int k = 1; k <= MUL_LAT; k++) begin
            checkOutput($sformatf("mul_busy_c%0d", k), 32'(busy), 32'(k < MUL_LAT));
            if (k < MUL_LAT) @(negedge clk);
        end
        waitIdle();

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].value, vecs[i].lat, vecs[i].tag);
            waitIdle();
            last_exp = vecs[i].value;
        end

        // kill in cycle 10 of a DIV
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill_busy", 32'(busy), 32'd0);
        checkOutput("kill_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);
        checkOutput("kill_result_kept", result, last_exp);
        applyStimulus(OP_DIV, 32'd1000, 32'd3, 32'd333, DIV_LAT, "after_kill");
        waitIdle();

        // back-to-back start in the DONE cycle
        @(negedge clk);
        applyStimulus(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "b2b_first");
        repeat (MUL_LAT - 1) @(negedge clk);
        checkOutput("b2b_first_done", 32'(done), 32'd1);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "b2b_second");
        checkOutput("b2b_no_double", 32'(done), 32'd0);
        waitIdle();

        // start while busy is ignored
        @(negedge clk);
        applyStimulus(OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, "busy_start");
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        repeat (40) @(negedge clk);

        // reset in the middle of CALC
        @(negedge clk);
        applyStimulus(OP_DIVU, 32'd1000, 32'd7, 32'd142, DIV_LAT, "reset_mid");
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus(OP_DIVU, 32'd1000, 32'd7, 32'd142, DIV_LAT, "after_reset");
        waitIdle();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
